// File: rtl/mips_isa_pkg.sv
// Shared MIPS opcode/funct encodings and the 4-bit mnemonic enumeration used by the
// instruction encoder and the control decoder.
package mips_isa_pkg;

    typedef enum logic [3:0] {
        OpAdd  = 4'd0,
        OpSub  = 4'd1,
        OpAnd  = 4'd2,
        OpOr   = 4'd3,
        OpSlt  = 4'd4,
        OpLw   = 4'd5,
        OpSw   = 4'd6,
        OpBeq  = 4'd7,
        OpAddi = 4'd8,
        OpJ    = 4'd9
    } mnemonic_t;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: mnemonic plus register/immediate/target fields to a 32-bit MIPS word,
// with a flag that is low for unsupported mnemonics.
module instr_field_pack
    import mips_isa_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        supported
);

    always_comb begin
        word      = 32'h0;
        supported = 1'b1;
        case (op)
            OpAdd:   word = {OPC_RTYPE, rs, rt, rd, 5'b0, FUNCT_ADD};
            OpSub:   word = {OPC_RTYPE, rs, rt, rd, 5'b0, FUNCT_SUB};
            OpAnd:   word = {OPC_RTYPE, rs, rt, rd, 5'b0, FUNCT_AND};
            OpOr:    word = {OPC_RTYPE, rs, rt, rd, 5'b0, FUNCT_OR};
            OpSlt:   word = {OPC_RTYPE, rs, rt, rd, 5'b0, FUNCT_SLT};
            OpLw:    word = {OPC_LW, rs, rt, imm};
            OpSw:    word = {OPC_SW, rs, rt, imm};
            OpBeq:   word = {OPC_BEQ, rs, rt, imm};
            OpAddi:  word = {OPC_ADDI, rs, rt, imm};
            OpJ:     word = {OPC_J, target};
            default: supported = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder / program loader: packs one descriptor per handshake and writes it to
// sequential instruction-memory words. Define INSTR_ENC_CHECKSUM_EN for the running XOR checksum.
module instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic [31:0]       checksum
);

    localparam int unsigned       DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {StIdle, StWrite, StFull} enc_state_t;

    enc_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              we;
    logic [31:0]       packed_word;
    logic              supported;

    instr_field_pack u_pack (
        .op        (op),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .imm       (imm),
        .target    (target),
        .word      (packed_word),
        .supported (supported)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        we      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (supported) begin
                        wdata_d = packed_word;
                        state_d = StWrite;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StWrite: begin
                we      = 1'b1;
                addr_d  = addr_q + 1'b1;
                count_d = count_q + 1'b1;
                state_d = (count_d == COUNT_MAX) ? StFull : StIdle;
            end
            StFull: ;
            default: state_d = StIdle;
        endcase
        // Restart wins over any handshake or pending write this cycle.
        if (clear) begin
            state_d = StIdle;
            addr_d  = BASE;
            count_d = '0;
            wdata_d = 32'h0;
            err_d   = 1'b0;
            we      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= BASE;
            count_q <= '0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

`ifdef INSTR_ENC_CHECKSUM_EN
    logic [31:0] chk_q, chk_d;

    always_comb begin
        chk_d = chk_q;
        if (clear) begin
            chk_d = 32'h0;
        end else if (we) begin
            chk_d = chk_q ^ wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chk_q <= 32'h0;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign checksum = chk_q;
`else
    assign checksum = 32'h0;
`endif

    assign in_ready   = (state_q == StIdle);
    assign imem_we    = we & ~reset;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign full       = (state_q == StFull);
    assign err        = err_q;

endmodule
